// File: rtl/rx_eth_pkg.sv
// Shared definitions for the Ethernet receive chain: FSM encoding and UDP constants.
package rx_eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_DROP
  } udp_state_t;

  localparam int         UDP_HDR_LEN  = 8;
  localparam logic [7:0] IP_PROTO_UDP = 8'd17;

endpackage

// File: rtl/rx_udp.sv
// UDP receive stage: strips the 8-byte UDP header, filters on protocol and
// destination port, trims Ethernet padding via the UDP Length field and forwards
// the payload through a single output register.
module rx_udp
  import rx_eth_pkg::*;
#(
  parameter logic [15:0] LOCAL_PORT  = 16'd8080,
  parameter bit          PORT_FILTER = 1'b1
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic        udp_enable,
  input  logic [7:0]  IP_Protocol,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [15:0] UDP_SrcPort,
  output logic [15:0] UDP_DestPort,
  output logic [15:0] UDP_Len,
  output logic        udp_len_err,
  output logic        udp_drop
);

  udp_state_t  state, nstate;
  logic [2:0]  hdr_cnt;
  logic [15:0] pay_rem;
  logic [7:0]  proto_q;
  logic        first_q;

  logic [7:0]  m_dat;
  logic        m_vld, m_usr, m_lst;

  logic        bypass, rdy_int, beat;
  logic        hdr_start, to_data, load_out, out_last;
  logic        len_err_d, drop_d, filter_bad;

  // Bypass only engages from IDLE once the output register has drained, so a
  // pending payload byte is never overwritten by the pass-through path.
  assign bypass  = (state == ST_IDLE) & ~udp_enable & ~m_vld;
  assign rdy_int = (state == ST_DATA) ? (~m_vld | m_axis_tready) : 1'b1;
  assign beat    = s_axis_tvalid & rdy_int & ~bypass;

  assign s_axis_tready = bypass ? m_axis_tready : rdy_int;
  assign m_axis_tdata  = bypass ? s_axis_tdata  : m_dat;
  assign m_axis_tvalid = bypass ? s_axis_tvalid : m_vld;
  assign m_axis_tuser  = bypass ? s_axis_tuser  : m_usr;
  assign m_axis_tlast  = bypass ? s_axis_tlast  : m_lst;

  assign filter_bad = (proto_q != IP_PROTO_UDP) | (PORT_FILTER & (UDP_DestPort != LOCAL_PORT));

  // State register.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) state <= ST_IDLE;
    else               state <= nstate;
  end

  // Next-state, pulse and datapath-strobe decode.
  always_comb begin
    nstate    = state;
    len_err_d = 1'b0;
    drop_d    = 1'b0;
    hdr_start = 1'b0;
    to_data   = 1'b0;
    load_out  = 1'b0;
    out_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (beat && s_axis_tuser && udp_enable) begin
          if (s_axis_tlast) len_err_d = 1'b1;
          else begin
            nstate    = ST_HEADER;
            hdr_start = 1'b1;
          end
        end
      end
      ST_HEADER: begin
        if (beat) begin
          if (hdr_cnt == 3'd7) begin
            // A tlast here ends the frame cleanly: only the filter and length
            // rules apply, and we return to IDLE instead of DROP/DATA.
            nstate = s_axis_tlast ? ST_IDLE : ST_DROP;
            if (filter_bad)                         drop_d    = 1'b1;
            else if (UDP_Len < 16'(UDP_HDR_LEN))    len_err_d = 1'b1;
            else if (UDP_Len != 16'(UDP_HDR_LEN) && !s_axis_tlast) begin
              nstate  = ST_DATA;
              to_data = 1'b1;
            end
          end else if (s_axis_tlast) begin
            len_err_d = 1'b1;
            nstate    = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (beat) begin
          load_out = 1'b1;
          out_last = (pay_rem == 16'd1) | s_axis_tlast;
          if (s_axis_tlast) begin
            nstate    = ST_IDLE;
            len_err_d = (pay_rem != 16'd1);
          end else if (pay_rem == 16'd1) begin
            nstate = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (beat && s_axis_tlast) nstate = ST_IDLE;
      end
      default: nstate = ST_IDLE;
    endcase
  end

  // Header capture, payload counters and status pulses.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      hdr_cnt      <= '0;
      pay_rem      <= '0;
      proto_q      <= '0;
      first_q      <= 1'b0;
      UDP_SrcPort  <= '0;
      UDP_DestPort <= '0;
      UDP_Len      <= '0;
      udp_len_err  <= 1'b0;
      udp_drop     <= 1'b0;
    end else begin
      udp_len_err <= len_err_d;
      udp_drop    <= drop_d;
      if (hdr_start) begin
        hdr_cnt           <= 3'd1;
        proto_q           <= IP_Protocol;
        UDP_SrcPort[15:8] <= s_axis_tdata;
      end
      if (state == ST_HEADER && beat) begin
        hdr_cnt <= hdr_cnt + 3'd1;
        case (hdr_cnt)
          3'd1: UDP_SrcPort[7:0]   <= s_axis_tdata;
          3'd2: UDP_DestPort[15:8] <= s_axis_tdata;
          3'd3: UDP_DestPort[7:0]  <= s_axis_tdata;
          3'd4: UDP_Len[15:8]      <= s_axis_tdata;
          3'd5: UDP_Len[7:0]       <= s_axis_tdata;
          default: ;
        endcase
      end
      if (to_data) begin
        pay_rem <= UDP_Len - 16'(UDP_HDR_LEN);
        first_q <= 1'b1;
      end else if (load_out) begin
        pay_rem <= pay_rem - 16'd1;
        first_q <= 1'b0;
      end
    end
  end

  // Output register: holds a beat until the consumer takes it.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      m_vld <= 1'b0;
      m_dat <= '0;
      m_usr <= 1'b0;
      m_lst <= 1'b0;
    end else if (load_out) begin
      m_vld <= 1'b1;
      m_dat <= s_axis_tdata;
      m_usr <= first_q;
      m_lst <= out_last;
    end else if (m_axis_tready) begin
      m_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_udp.sv
// Randomised bench for rx_udp: each frame is run through a datagram-level
// reference model (header fields, payload/pad/truncation arithmetic) and the
// captured output stream and status pulses are compared against it.
module tb_rx_udp;

  localparam logic [15:0] LP = 16'd8080;

  logic        s_axis_aclk = 1'b0;
  logic        s_axis_areset = 1'b1;
  logic        udp_enable = 1'b1;
  logic [7:0]  IP_Protocol = 8'd17;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [15:0] UDP_SrcPort, UDP_DestPort, UDP_Len;
  logic        udp_len_err, udp_drop;

  rx_udp #(.LOCAL_PORT(LP), .PORT_FILTER(1'b1)) dut (
    .s_axis_aclk(s_axis_aclk), .s_axis_areset(s_axis_areset), .udp_enable(udp_enable),
    .IP_Protocol(IP_Protocol), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .UDP_SrcPort(UDP_SrcPort),
    .UDP_DestPort(UDP_DestPort), .UDP_Len(UDP_Len), .udp_len_err(udp_len_err), .udp_drop(udp_drop)
  );

  always #5 s_axis_aclk = ~s_axis_aclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [9:0] out_q[$];
  int n_err = 0, n_drop = 0, viol = 0;
  int drv_idx = -1, rdy_lo = 1, rdy_hi = 0;

  always @(negedge s_axis_aclk) begin
    if (!s_axis_areset) begin
      if (m_axis_tvalid && m_axis_tready)
        out_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      if (udp_len_err) n_err++;
      if (udp_drop)    n_drop++;
      if (drv_idx >= rdy_lo && drv_idx <= rdy_hi &&
          s_axis_tready !== (!m_axis_tvalid || m_axis_tready))
        viol++;
    end
  end

  // ---------------- downstream ready ----------------
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 toggle every cycle
  initial begin
    forever begin
      @(posedge s_axis_aclk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 3) != 0);
        default: m_axis_tready = !m_axis_tready;
      endcase
    end
  end

  // ---------------- frame building / model ----------------
  logic [7:0] frm[$];
  logic [9:0] exp_q[$];
  int e_err, e_drop;

  task automatic build(input logic [15:0] src, input logic [15:0] dst,
                       input logic [15:0] len, input int nbytes);
    frm.delete();
    frm.push_back(src[15:8]); frm.push_back(src[7:0]);
    frm.push_back(dst[15:8]); frm.push_back(dst[7:0]);
    frm.push_back(len[15:8]); frm.push_back(len[7:0]);
    frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
    while (frm.size() < nbytes) frm.push_back(8'($urandom));
    while (frm.size() > nbytes) void'(frm.pop_back());
  endtask

  // Datagram-level expectation: what payload must appear and which pulses fire.
  task automatic model(input logic [7:0] proto, input bit en);
    int n, pl, avail, k;
    logic [15:0] dst, len;
    exp_q.delete();
    e_err = 0; e_drop = 0; rdy_lo = 1; rdy_hi = 0;
    n = frm.size();
    if (!en) begin
      for (int j = 0; j < n; j++) exp_q.push_back({j == 0, j == n - 1, frm[j]});
      return;
    end
    if (n < 8) begin e_err = 1; return; end
    dst = {frm[2], frm[3]};
    len = {frm[4], frm[5]};
    if (proto != 8'd17 || dst != LP) e_drop = 1;
    else if (len < 8) e_err = 1;
    else if (len > 8 && n > 8) begin
      pl    = int'(len) - 8;
      avail = n - 8;
      k     = (pl < avail) ? pl : avail;
      for (int j = 0; j < k; j++) exp_q.push_back({j == 0, j == k - 1, frm[8 + j]});
      if (avail < pl) e_err = 1;
      rdy_lo = 8; rdy_hi = 8 + k - 1;
    end
  endtask

  task automatic send(input int nsend);
    bit acc;
    int guard;
    for (int i = 0; i < nsend; i++) begin
      drv_idx      = i;
      s_axis_tdata = frm[i];
      s_axis_tuser = (i == 0);
      s_axis_tlast = (i == frm.size() - 1);
      acc = 1'b0; guard = 0;
      while (!acc) begin
        s_axis_tvalid = ($urandom_range(0, 3) != 0);
        @(negedge s_axis_aclk);
        acc = s_axis_tvalid && s_axis_tready;
        @(posedge s_axis_aclk);
        #1;
        guard++;
        if (guard > 1000) begin
          chk("input_stall_timeout", 32'(guard), 32'd0);
          acc = 1'b1;
        end
      end
    end
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    drv_idx = -1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] proto);
    int b_out, b_err, b_drop, b_viol, w, got_n;
    b_out = out_q.size(); b_err = n_err; b_drop = n_drop; b_viol = viol;
    model(proto, udp_enable);
    IP_Protocol = proto;
    send(frm.size());
    w = 0;
    while (m_axis_tvalid && w < 300) begin @(negedge s_axis_aclk); w++; end
    if (w >= 300) chk({tag, " drain_timeout"}, 32'(w), 32'd0);
    repeat (3) @(negedge s_axis_aclk);
    got_n = out_q.size() - b_out;
    chk({tag, " beats"}, 32'(got_n), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < got_n; j++)
      chk($sformatf("%s beat%0d", tag, j), 32'(out_q[b_out + j]), 32'(exp_q[j]));
    chk({tag, " len_err"}, 32'(n_err - b_err), 32'(e_err));
    chk({tag, " drop"}, 32'(n_drop - b_drop), 32'(e_drop));
    chk({tag, " in_ready"}, 32'(viol - b_viol), 32'd0);
    if (udp_enable && frm.size() >= 8) begin
      chk({tag, " src"}, 32'(UDP_SrcPort), 32'({frm[0], frm[1]}));
      chk({tag, " dst"}, 32'(UDP_DestPort), 32'({frm[2], frm[3]}));
      chk({tag, " len"}, 32'(UDP_Len), 32'({frm[4], frm[5]}));
    end
    rdy_lo = 1; rdy_hi = 0;
    @(posedge s_axis_aclk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len, n, r;
    logic [15:0] dst;
    logic [7:0]  proto;
    logic [15:0] held_len;

    #12;
    chk("rst m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst m_tdata",  32'(m_axis_tdata),  32'd0);
    chk("rst m_tuser",  32'(m_axis_tuser),  32'd0);
    chk("rst m_tlast",  32'(m_axis_tlast),  32'd0);
    chk("rst ports",    32'({UDP_SrcPort, UDP_DestPort}), 32'd0);
    chk("rst len",      32'(UDP_Len), 32'd0);
    chk("rst pulses",   32'({udp_len_err, udp_drop}), 32'd0);
    chk("rst s_tready", 32'(s_axis_tready), 32'd1);
    @(posedge s_axis_aclk); #1;
    s_axis_areset = 1'b0;
    @(posedge s_axis_aclk); #1;

    // good datagram
    rdy_mode = 0;
    build(16'h1F90, 16'h1F90, 16'h000C, 12);
    frm[8] = 8'hDE; frm[9] = 8'hAD; frm[10] = 8'hBE; frm[11] = 8'hEF;
    run_frame("good", 8'd17);

    // Ethernet-padded: 2 payload bytes + 16 pad
    build(16'h1234, LP, 16'h000A, 8 + 2 + 16);
    run_frame("padded", 8'd17);

    // port filter, then a good frame
    build(16'h1234, 16'h0035, 16'h0010, 24);
    run_frame("filter", 8'd17);
    build(16'h4321, LP, 16'h0010, 16);
    run_frame("after_filter", 8'd17);

    // wrong protocol
    build(16'h4321, LP, 16'h0010, 16);
    run_frame("proto", 8'd6);

    // truncated: Len=20, only 5 payload bytes
    build(16'h0001, LP, 16'h0014, 13);
    run_frame("trunc", 8'd17);

    // short length field, empty payload, short header
    build(16'h0001, LP, 16'h0005, 20);
    run_frame("len_lt8", 8'd17);
    build(16'h0001, LP, 16'h0008, 14);
    run_frame("len_eq8", 8'd17);
    build(16'h0001, LP, 16'h0010, 5);
    run_frame("short_hdr", 8'd17);
    build(16'h0001, LP, 16'h0010, 1);
    run_frame("one_byte", 8'd17);

    // backpressure toggling on a 64-byte payload
    rdy_mode = 2;
    build(16'hAAAA, LP, 16'd72, 72);
    run_frame("bp64", 8'd17);

    // randomised frames under random backpressure
    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      proto = ($urandom_range(0, 9) == 0) ? 8'd6 : 8'd17;
      dst   = ($urandom_range(0, 4) == 0) ? 16'($urandom) : LP;
      r = $urandom_range(0, 9);
      if (r == 0) len = $urandom_range(0, 7);
      else        len = $urandom_range(9, 40);
      if (r == 1 && len > 9) n = $urandom_range(9, len - 1);         // truncated payload
      else if (r == 2)       n = $urandom_range(1, 7);               // truncated header
      else                   n = (len < 8 ? 8 : len) + $urandom_range(0, 12);
      build(16'($urandom), dst, 16'(len), n);
      run_frame($sformatf("rnd%0d", t), proto);
    end

    // bypass: stream passes unchanged, header registers held
    held_len = UDP_Len;
    udp_enable = 1'b0;
    rdy_mode = 1;
    build(16'h5555, 16'h0035, 16'h0003, 10);
    run_frame("bypass", 8'd17);
    chk("bypass len_held", 32'(UDP_Len), 32'(held_len));
    udp_enable = 1'b1;
    @(posedge s_axis_aclk); #1;

    // asynchronous reset in the middle of the payload
    rdy_mode = 0;
    build(16'h7777, LP, 16'd28, 28);
    IP_Protocol = 8'd17;
    send(14);
    @(posedge s_axis_aclk); #3;
    s_axis_areset = 1'b1;
    #1;
    chk("midrst m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("midrst m_tdata",  32'(m_axis_tdata),  32'd0);
    chk("midrst len",      32'(UDP_Len),       32'd0);
    @(posedge s_axis_aclk); #1;
    s_axis_areset = 1'b0;
    @(posedge s_axis_aclk); #1;
    build(16'h8888, LP, 16'd20, 26);
    run_frame("after_rst", 8'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
